// File: rtl/stream_mux_pkt.sv
// Packet-locking, registered N:1 valid-ready stream multiplexer.
// The selection is frozen from the first accepted beat until the beat flagged last.
module stream_mux_pkt #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_INP      = 4,
  parameter int unsigned SEL_WIDTH  = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_INP*DATA_WIDTH-1:0] inp_data_i,
  input  logic [N_INP-1:0]            inp_last_i,
  input  logic [N_INP-1:0]            inp_valid_i,
  output logic [N_INP-1:0]            inp_ready_o,
  input  logic [SEL_WIDTH-1:0]        inp_sel_i,
  output logic [DATA_WIDTH-1:0]       oup_data_o,
  output logic                        oup_last_o,
  output logic                        oup_valid_o,
  input  logic                        oup_ready_i,
  output logic                        locked_o,
  output logic [SEL_WIDTH-1:0]        locked_sel_o,
  output logic                        sel_err_o
);

  if (N_INP < 1) begin : g_bad_n_inp
    $fatal(1, "stream_mux_pkt: N_INP must be at least 1");
  end

  // Handshakes: a beat moves on a port in any cycle where its valid and ready
  // are both high at the rising clock edge. Ready may depend combinationally
  // on oup_ready_i and inp_sel_i; valid never depends on ready.

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [SEL_WIDTH:0] N_INP_W = (SEL_WIDTH+1)'(N_INP);

  state_e                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [SEL_WIDTH-1:0]   eff_sel;
  logic                   sel_ok;
  logic                   stage_ready;
  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   in_hs;

  assign eff_sel     = (state_q == LOCKED) ? sel_q : inp_sel_i;
  assign sel_ok      = ({1'b0, eff_sel} < N_INP_W);
  assign stage_ready = !oup_valid_o || oup_ready_i;
  assign in_hs       = sel_valid && stage_ready;

  // Input mux; an out-of-range select matches no input, so nothing is ready.
  always_comb begin
    sel_valid   = 1'b0;
    sel_last    = 1'b0;
    sel_data    = '0;
    inp_ready_o = '0;
    for (int unsigned i = 0; i < N_INP; i++) begin
      if (eff_sel == SEL_WIDTH'(i)) begin
        sel_valid      = inp_valid_i[i];
        sel_last       = inp_last_i[i];
        sel_data       = inp_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        inp_ready_o[i] = stage_ready;
      end
    end
  end

  assign sel_err_o = (state_q == IDLE) && !sel_ok && (|inp_valid_i);

  // Single output slot; reloads on the same cycle it drains for full throughput.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oup_valid_o <= 1'b0;
      oup_data_o  <= '0;
      oup_last_o  <= 1'b0;
    end else if (in_hs) begin
      oup_valid_o <= 1'b1;
      oup_data_o  <= sel_data;
      oup_last_o  <= sel_last;
    end else if (oup_ready_i) begin
      oup_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (in_hs && !sel_last) begin
          state_d = LOCKED;
          sel_d   = eff_sel;
        end
      end
      LOCKED: begin
        if (in_hs && sel_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    locked_o     = (state_q == LOCKED);
    locked_sel_o = sel_q;
  end

endmodule

// File: tb/tb_stream_mux_pkt.sv
// Bench for stream_mux_pkt: directed scenarios plus random traffic, with a
// packet-ownership reference model and an expected-beat queue.
module tb_stream_mux_pkt;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int N3 = 3;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (N_INP=4)
  logic [N*DW-1:0] inp_data  = '0;
  logic [N-1:0]    inp_last  = '0;
  logic [N-1:0]    inp_valid = '0;
  logic [N-1:0]    inp_ready;
  logic [SW-1:0]   inp_sel   = '0;
  logic [DW-1:0]   oup_data;
  logic            oup_last;
  logic            oup_valid;
  logic            oup_ready = 1'b0;
  logic            locked;
  logic [SW-1:0]   locked_sel;
  logic            sel_err;

  // Secondary DUT (N_INP=3) for out-of-range selects
  logic [N3*DW-1:0] inp_data3  = '0;
  logic [N3-1:0]    inp_last3  = '0;
  logic [N3-1:0]    inp_valid3 = '0;
  logic [N3-1:0]    inp_ready3;
  logic [SW-1:0]    inp_sel3   = '0;
  logic [DW-1:0]    oup_data3;
  logic             oup_last3;
  logic             oup_valid3;
  logic             oup_ready3 = 1'b1;
  logic             locked3;
  logic [SW-1:0]    locked_sel3;
  logic             sel_err3;

  stream_mux_pkt #(.DATA_WIDTH(DW), .N_INP(N)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .inp_data_i(inp_data), .inp_last_i(inp_last), .inp_valid_i(inp_valid),
    .inp_ready_o(inp_ready), .inp_sel_i(inp_sel),
    .oup_data_o(oup_data), .oup_last_o(oup_last), .oup_valid_o(oup_valid),
    .oup_ready_i(oup_ready), .locked_o(locked), .locked_sel_o(locked_sel),
    .sel_err_o(sel_err)
  );

  stream_mux_pkt #(.DATA_WIDTH(DW), .N_INP(N3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .inp_data_i(inp_data3), .inp_last_i(inp_last3), .inp_valid_i(inp_valid3),
    .inp_ready_o(inp_ready3), .inp_sel_i(inp_sel3),
    .oup_data_o(oup_data3), .oup_last_o(oup_last3), .oup_valid_o(oup_valid3),
    .oup_ready_i(oup_ready3), .locked_o(locked3), .locked_sel_o(locked_sel3),
    .sel_err_o(sel_err3)
  );

  // Reference model: which input owns the current packet (-1 = none) and the
  // beats accepted but not yet delivered, as {last, data}.
  int owner = -1;
  logic [DW:0] exp_q[$];

  task automatic sb_cycle();
    int          eff;
    logic        stage_rdy;
    logic [N-1:0] exp_rdy;
    logic [DW:0] got;
    logic [DW:0] exp_b;
    if (!rst_n) begin
      exp_q.delete();
      owner = -1;
      return;
    end
    eff = (owner >= 0) ? owner : int'(inp_sel);
    stage_rdy = (exp_q.size() == 0) || oup_ready;
    exp_rdy = '0;
    if (eff < N && stage_rdy) exp_rdy[eff] = 1'b1;
    total++;
    if (inp_ready !== exp_rdy) begin
      bad++; $display("FAIL sb_ready: got %b want %b t=%0t", inp_ready, exp_rdy, $time);
    end
    total++;
    if (oup_valid !== (exp_q.size() != 0)) begin
      bad++; $display("FAIL sb_valid: got %b want %0d t=%0t", oup_valid, exp_q.size(), $time);
    end
    total++;
    if (locked !== (owner >= 0)) begin
      bad++; $display("FAIL sb_locked: got %b want owner %0d t=%0t", locked, owner, $time);
    end
    if (owner >= 0) begin
      total++;
      if (locked_sel !== SW'(owner)) begin
        bad++; $display("FAIL sb_locked_sel: got %0d want %0d t=%0t", locked_sel, owner, $time);
      end
    end
    total++;
    if (sel_err !== 1'b0) begin
      bad++; $display("FAIL sb_sel_err: got %b want 0 t=%0t", sel_err, $time);
    end
    if (exp_q.size() != 0 && oup_ready) begin
      got = {oup_last, oup_data};
      exp_b = exp_q.pop_front();
      total++;
      if (got !== exp_b) begin
        bad++; $display("FAIL sb_beat: got %h want %h t=%0t", got, exp_b, $time);
      end
    end
    if (eff < N && inp_valid[eff] && stage_rdy) begin
      exp_q.push_back({inp_last[eff], inp_data[eff*DW +: DW]});
      owner = inp_last[eff] ? -1 : eff;
    end
  endtask

  // One clock: scoreboard on the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    sb_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic [DW-1:0] d, input logic l, input logic v);
    inp_data[i*DW +: DW] = d;
    inp_last[i]  = l;
    inp_valid[i] = v;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({oup_valid, oup_last, oup_data} !== '0) begin
      bad++; $display("FAIL reset_out: got %b %b %h want 0 0 0", oup_valid, oup_last, oup_data);
    end
    total++;
    if ({locked, locked_sel, sel_err} !== '0) begin
      bad++; $display("FAIL reset_lock: got %b %0d %b want 0 0 0", locked, locked_sel, sel_err);
    end
    total++;
    if ({oup_valid3, locked3, sel_err3} !== 3'b000) begin
      bad++; $display("FAIL reset_dut3: got %b %b %b want 0 0 0", oup_valid3, locked3, sel_err3);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_packet();
    logic [DW-1:0] beats [3];
    beats[0] = 16'h00A0; beats[1] = 16'h00A1; beats[2] = 16'h00A2;
    inp_sel = 2'd2;
    oup_ready = 1'b1;
    set_in(2, beats[0], 1'b0, 1'b1);
    #1;
    total++;
    if (inp_ready !== 4'b0100) begin
      bad++; $display("FAIL basic_ready: got %b want 0100", inp_ready);
    end
    for (int k = 0; k < 3; k++) begin
      set_in(2, beats[k], (k == 2), 1'b1);
      tick();
      total++;
      if ({oup_valid, oup_last, oup_data} !== {1'b1, (k == 2), beats[k]}) begin
        bad++; $display("FAIL basic_beat%0d: got %b %b %h want 1 %0d %h", k, oup_valid, oup_last, oup_data, (k == 2), beats[k]);
      end
      total++;
      if (locked !== (k < 2)) begin
        bad++; $display("FAIL basic_locked%0d: got %b want %0d", k, locked, (k < 2));
      end
      if (k < 2) begin
        total++;
        if (locked_sel !== 2'd2) begin
          bad++; $display("FAIL basic_locked_sel: got %0d want 2", locked_sel);
        end
      end
    end
    inp_valid = '0;
    tick();
    total++;
    if (oup_valid !== 1'b0) begin
      bad++; $display("FAIL basic_drain: got %b want 0", oup_valid);
    end
  endtask

  task automatic test_mid_packet_switch();
    inp_sel = 2'd1;
    oup_ready = 1'b1;
    set_in(1, 16'h00B0, 1'b0, 1'b1);
    set_in(3, 16'h00C0, 1'b1, 1'b1);
    tick();
    inp_sel = 2'd3;
    set_in(1, 16'h00B1, 1'b0, 1'b1);
    #1;
    total++;
    if (inp_ready !== 4'b0010) begin
      bad++; $display("FAIL switch_hold1: got %b want 0010", inp_ready);
    end
    tick();
    set_in(1, 16'h00B2, 1'b1, 1'b1);
    #1;
    total++;
    if (inp_ready !== 4'b0010) begin
      bad++; $display("FAIL switch_hold2: got %b want 0010", inp_ready);
    end
    tick();
    set_in(1, 16'h0000, 1'b0, 1'b0);
    #1;
    total++;
    if (inp_ready !== 4'b1000) begin
      bad++; $display("FAIL switch_follow: got %b want 1000", inp_ready);
    end
    tick();
    total++;
    if ({oup_valid, oup_last, oup_data} !== {1'b1, 1'b1, 16'h00C0}) begin
      bad++; $display("FAIL switch_c0: got %b %b %h want 1 1 00c0", oup_valid, oup_last, oup_data);
    end
    set_in(3, 16'h0000, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_backpressure();
    inp_sel = 2'd0;
    oup_ready = 1'b1;
    set_in(0, 16'h00D0, 1'b0, 1'b1);
    tick();
    oup_ready = 1'b0;
    set_in(0, 16'h00D1, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (inp_ready !== 4'b0000) begin
        bad++; $display("FAIL bp_ready%0d: got %b want 0000", k, inp_ready);
      end
      total++;
      if ({oup_valid, oup_data} !== {1'b1, 16'h00D0}) begin
        bad++; $display("FAIL bp_hold%0d: got %b %h want 1 00d0", k, oup_valid, oup_data);
      end
      tick();
    end
    oup_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      set_in(0, DW'(16'h00D0 + k), (k == 3), 1'b1);
      tick();
    end
    inp_valid = '0;
    tick();
    total++;
    if (oup_valid !== 1'b0) begin
      bad++; $display("FAIL bp_drain: got %b want 0", oup_valid);
    end
  endtask

  task automatic test_single_beat();
    int s;
    oup_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s = (k % 2 == 1) ? 3 : 0;
      inp_valid = '0;
      inp_sel = SW'(s);
      set_in(s, DW'(16'h5000 + k), 1'b1, 1'b1);
      tick();
      total++;
      if (locked !== 1'b0) begin
        bad++; $display("FAIL single_locked%0d: got %b want 0", k, locked);
      end
      total++;
      if ({oup_valid, oup_last, oup_data} !== {1'b1, 1'b1, DW'(16'h5000 + k)}) begin
        bad++; $display("FAIL single_beat%0d: got %b %b %h want 1 1 %h", k, oup_valid, oup_last, oup_data, DW'(16'h5000 + k));
      end
    end
    inp_valid = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      inp_sel = SW'($urandom_range(0, N - 1));
      for (int i = 0; i < N; i++)
        set_in(i, DW'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      oup_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    // Close any open packet so later scenarios start unlocked.
    for (int k = 0; k < 10 && owner >= 0; k++) begin
      inp_valid = '0;
      oup_ready = 1'b1;
      set_in(owner, DW'($urandom), 1'b1, 1'b1);
      tick();
    end
    inp_valid = '0;
    oup_ready = 1'b1;
    tick();
    tick();
    total++;
    if ({locked, oup_valid} !== 2'b00) begin
      bad++; $display("FAIL random_end: got locked %b valid %b want 0 0", locked, oup_valid);
    end
  endtask

  task automatic test_out_of_range();
    inp_data3 = {16'h3332, 16'h3331, 16'h3330};
    inp_last3 = 3'b000;
    inp_valid3 = 3'b111;
    inp_sel3 = 2'd3;
    oup_ready3 = 1'b1;
    #1;
    total++;
    if ({sel_err3, inp_ready3} !== {1'b1, 3'b000}) begin
      bad++; $display("FAIL oor_err: got err %b ready %b want 1 000", sel_err3, inp_ready3);
    end
    tick();
    total++;
    if ({oup_valid3, sel_err3, locked3} !== 3'b010) begin
      bad++; $display("FAIL oor_hold: got valid %b err %b locked %b want 0 1 0", oup_valid3, sel_err3, locked3);
    end
    inp_sel3 = 2'd2;
    #1;
    total++;
    if ({sel_err3, inp_ready3} !== {1'b0, 3'b100}) begin
      bad++; $display("FAIL oor_inrange: got err %b ready %b want 0 100", sel_err3, inp_ready3);
    end
    tick();
    total++;
    if ({oup_valid3, oup_data3, locked3, locked_sel3} !== {1'b1, 16'h3332, 1'b1, 2'd2}) begin
      bad++; $display("FAIL oor_accept: got %b %h %b %0d want 1 3332 1 2", oup_valid3, oup_data3, locked3, locked_sel3);
    end
    inp_sel3 = 2'd3;
    inp_last3 = 3'b100;
    #1;
    total++;
    if ({sel_err3, inp_ready3} !== {1'b0, 3'b100}) begin
      bad++; $display("FAIL oor_locked: got err %b ready %b want 0 100", sel_err3, inp_ready3);
    end
    tick();
    total++;
    if ({locked3, oup_last3} !== 2'b01) begin
      bad++; $display("FAIL oor_unlock: got locked %b last %b want 0 1", locked3, oup_last3);
    end
    inp_valid3 = '0;
    inp_sel3 = '0;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    oup_ready = 1'b0;
    inp_sel = 2'd1;
    set_in(1, 16'h00E0, 1'b0, 1'b1);
    tick();
    total++;
    if ({oup_valid, locked} !== 2'b11) begin
      bad++; $display("FAIL rmp_setup: got valid %b locked %b want 1 1", oup_valid, locked);
    end
    set_in(1, 16'h00E1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    total++;
    if ({oup_valid, locked, locked_sel, oup_data} !== {1'b0, 1'b0, 2'd0, 16'h0000}) begin
      bad++; $display("FAIL rmp_reset: got %b %b %0d %h want 0 0 0 0000", oup_valid, locked, locked_sel, oup_data);
    end
    tick();
    rst_n = 1'b1;
    inp_valid = '0;
    inp_sel = 2'd2;
    oup_ready = 1'b1;
    set_in(2, 16'h00F0, 1'b1, 1'b1);
    tick();
    total++;
    if ({oup_valid, oup_last, oup_data, locked} !== {1'b1, 1'b1, 16'h00F0, 1'b0}) begin
      bad++; $display("FAIL rmp_after: got %b %b %h %b want 1 1 00f0 0", oup_valid, oup_last, oup_data, locked);
    end
    inp_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_mid_packet_switch();
    test_backpressure();
    test_single_beat();
    test_random();
    test_out_of_range();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
